draw_cursor_multi: RTL and testbench
====================================

Name: draw_cursor_multi

Overview:
Parametrised successor to the fixed cursor drawer. On an `init` pulse it latches a cursor position, shape mode and colour. It then rasterises a SIZE x SIZE cursor window into framebuffer pixel writes (`paint`/`out_x`/`out_y`/`px_data`), clipping at the screen edges and honouring write backpressure. It sits between the paint controller and the framebuffer write port.

Parameters:
COORD_W, 6, width of in_x/in_y
OUT_W, 8, width of out_x/out_y (OUT_W >= COORD_W)
PX_W, 8, pixel data width
SIZE, 5, cursor window edge length in pixels (odd, 3..15)
SCREEN_W, 64, visible columns; writes with x >= SCREEN_W are suppressed
SCREEN_H, 64, visible rows; writes with y >= SCREEN_H are suppressed

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
init  in  1  start request, sampled only in IDLE
in_x  in  COORD_W  cursor top-left column
in_y  in  COORD_W  cursor top-left row
mode  in  2  shape: 0 box outline, 1 filled, 2 crosshair, 3 diagonal X
color  in  PX_W  pixel value written
paint_ready  in  1  framebuffer accepts current write this cycle
paint  out  1  write request
out_x  out  OUT_W  write column
out_y  out  OUT_W  write row
px_data  out  PX_W  write data
busy  out  1  high from the cycle after an accepted init until the cycle cursor_done is high, inclusive
cursor_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): state IDLE. paint, out_x, out_y, px_data, busy, cursor_done, and the window counters cx and cy all go to 0. Reset mid-operation aborts the draw with no done pulse.
- All outputs are registered.
- IDLE: on `init`=1 at posedge, latch in_x, in_y, mode and color. Set cx=cy=0 and busy=1, then go to SCAN. Changes to the inputs after the latch have no effect. `init` outside IDLE is ignored.
- Window is scanned in raster order: cx from 0 to SIZE-1 within each row, cy from 0 to SIZE-1. C = SIZE/2 (integer division).
- Shape hit per mode:
  - box: cx==0, cx==SIZE-1, cy==0 or cy==SIZE-1
  - filled: always
  - crosshair: cx==C or cy==C
  - X: cx==cy or cx+cy==SIZE-1
- Clipping:
  - px = in_x+cx and py = in_y+cy, zero-extended and computed in OUT_W+1 bits (no wrap).
  - A position is visible iff px < SCREEN_W and py < SCREEN_H.
- Emit = hit AND visible.
- SCAN (one position per cycle):
  - If emit: set paint=1, out_x=px[OUT_W-1:0], out_y=py[OUT_W-1:0], px_data=latched color, then go to PAINT.
  - Otherwise advance the counter. If that was the last position (cx==cy==SIZE-1), go to DONE.
- PAINT: paint, out_x, out_y and px_data are held stable until paint_ready=1 at a posedge. On that edge: paint=0, advance the counter, then go to SCAN, or to DONE if that was the last position. paint_ready is ignored whenever paint=0.
- DONE (one cycle): cursor_done=1, busy=1. On the next edge cursor_done=0, busy=0, go to IDLE. A new init is accepted from IDLE the following cycle.
- Timing with paint_ready tied high:
  - each emitted pixel costs 2 cycles; each skipped position costs 1 cycle;
  - total from init edge to cursor_done high = 2*E + (SIZE^2 - E) + 1 cycles, where E is the emitted count.
- Fully off-screen cursor (all positions clipped): no paint. cursor_done still pulses after SIZE^2+1 cycles.
- Between writes, out_x/out_y/px_data keep their last values. Only paint qualifies them.

Test Plan:
- Reset: hold rst=0 mid-draw (mode 1, in_x=10) -> all outputs 0 immediately with no clock edge. After release the block is IDLE, with no done pulse and busy=0.
- Filled, ready tied 1: in_x=10, in_y=20, mode=1, color=8'hA5 -> 25 writes, (10,20),(11,20)..(14,24) in raster order, all px_data=A5. cursor_done is high exactly 51 cycles after the init edge; busy falls the next cycle.
- Box and crosshair, ready tied 1: mode=0 at (0,0) -> 16 writes, centre (2,2) absent, done at cycle 42. mode=2 -> 9 writes: column x=2 and row y=2, with (2,2) written once.
- Diagonal X, ready tied 1: mode=3 at (5,5) -> 9 writes: (5,5),(9,5),(6,6),(8,6),(7,7),(6,8),(8,8),(5,9),(9,9).
- Clipping: in_x=62, in_y=61, mode=1 -> 6 writes, x in {62,63}, y in {61,62,63}. in_x=63, in_y=63 -> 1 write (63,63). All out_x/out_y values are < 64.
- Backpressure: mode=1 with paint_ready toggling randomly -> each write is held stable while ready=0 and accepted exactly once. The sequence matches the ready-tied-1 case. init=1 pulsed mid-draw is ignored, with no restart and no second done pulse.

Source files
------------

// File: rtl/draw_cursor_multi.sv
// Rasterises a SIZE x SIZE cursor shape into framebuffer pixel writes,
// clipping at the screen edges and holding each write until it is accepted.
module draw_cursor_multi #(
    parameter int COORD_W  = 6,
    parameter int OUT_W    = 8,
    parameter int PX_W     = 8,
    parameter int SIZE     = 5,
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [1:0]         mode,
    input  logic [PX_W-1:0]    color,
    input  logic               paint_ready,
    output logic               paint,
    output logic [OUT_W-1:0]   out_x,
    output logic [OUT_W-1:0]   out_y,
    output logic [PX_W-1:0]    px_data,
    output logic               busy,
    output logic               cursor_done
);

    localparam int CNT_W = $clog2(SIZE);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] CENTRE = CNT_W'(SIZE / 2);
    localparam logic [CNT_W:0]   ANTI   = (CNT_W + 1)'(SIZE - 1);
    localparam logic [OUT_W:0]   LIM_X  = (OUT_W + 1)'(SCREEN_W);
    localparam logic [OUT_W:0]   LIM_Y  = (OUT_W + 1)'(SCREEN_H);

    // S_WRAP is the cycle between the final position and the done pulse.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_PAINT,
        S_WRAP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cx_q, cx_d, cy_q, cy_d;
    logic [COORD_W-1:0]   x0_q, x0_d, y0_q, y0_d;
    logic [1:0]           mode_q, mode_d;
    logic [PX_W-1:0]      color_q, color_d;
    logic                 paint_q, paint_d;
    logic [OUT_W-1:0]     out_x_q, out_x_d, out_y_q, out_y_d;
    logic [PX_W-1:0]      px_q, px_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 hit;
    logic                 emit;
    logic                 lastPos;
    logic [OUT_W:0]       px, py;

    // Shape membership and clipping for the current window position.
    always_comb begin
        hit = 1'b0;
        case (mode_q)
            2'd0:    hit = (cx_q == '0) || (cx_q == LAST) || (cy_q == '0) || (cy_q == LAST);
            2'd1:    hit = 1'b1;
            2'd2:    hit = (cx_q == CENTRE) || (cy_q == CENTRE);
            default: hit = (cx_q == cy_q) || (({1'b0, cx_q} + {1'b0, cy_q}) == ANTI);
        endcase
        px      = (OUT_W + 1)'(x0_q) + (OUT_W + 1)'(cx_q);
        py      = (OUT_W + 1)'(y0_q) + (OUT_W + 1)'(cy_q);
        emit    = hit && (px < LIM_X) && (py < LIM_Y);
        lastPos = (cx_q == LAST) && (cy_q == LAST);
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        mode_d  = mode_q;
        color_d = color_q;
        paint_d = paint_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        px_d    = px_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (init) begin
                    x0_d    = in_x;
                    y0_d    = in_y;
                    mode_d  = mode;
                    color_d = color;
                    cx_d    = '0;
                    cy_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (emit) begin
                    paint_d = 1'b1;
                    out_x_d = px[OUT_W-1:0];
                    out_y_d = py[OUT_W-1:0];
                    px_d    = color_q;
                    state_d = S_PAINT;
                end else begin
                    if (cx_q == LAST) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    state_d = lastPos ? S_WRAP : S_SCAN;
                end
            end
            S_PAINT: begin
                if (paint_ready) begin
                    paint_d = 1'b0;
                    if (cx_q == LAST) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    state_d = lastPos ? S_WRAP : S_SCAN;
                end
            end
            S_WRAP: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            mode_q  <= '0;
            color_q <= '0;
            paint_q <= 1'b0;
            out_x_q <= '0;
            out_y_q <= '0;
            px_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            paint_q <= paint_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            px_q    <= px_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign paint       = paint_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign px_data     = px_q;
    assign busy        = busy_q;
    assign cursor_done = done_q;

endmodule

// File: tb/tb_draw_cursor_multi.sv
// Scoreboard bench for draw_cursor_multi: a loop-based shape model queues the
// expected writes and a negedge monitor pops them as the DUT's writes are accepted.
module tb_draw_cursor_multi;

    localparam int COORD_W  = 6;
    localparam int OUT_W    = 8;
    localparam int PX_W     = 8;
    localparam int SIZE     = 5;
    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               init;
    logic [COORD_W-1:0] in_x, in_y;
    logic [1:0]         mode;
    logic [PX_W-1:0]    color;
    logic               paint_ready = 1'b1;
    logic               paint;
    logic [OUT_W-1:0]   out_x, out_y;
    logic [PX_W-1:0]    px_data;
    logic               busy;
    logic               cursor_done;

    typedef struct packed {
        logic [OUT_W-1:0] x;
        logic [OUT_W-1:0] y;
        logic [PX_W-1:0]  d;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  acceptCount = 0;
    int  doneCount = 0;
    bit  readyRandom = 1'b0;
    bit  holdValid = 1'b0;
    wr_t holdVal;

    draw_cursor_multi #(
        .COORD_W(COORD_W), .OUT_W(OUT_W), .PX_W(PX_W),
        .SIZE(SIZE), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .clk(clk), .rst(rst), .init(init), .in_x(in_x), .in_y(in_y),
        .mode(mode), .color(color), .paint_ready(paint_ready),
        .paint(paint), .out_x(out_x), .out_y(out_y), .px_data(px_data),
        .busy(busy), .cursor_done(cursor_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        paint_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Cursor shape rules applied over the window coordinates; returns the write count.
    function automatic int modelPush(input int x0, input int y0, input int m, input logic [PX_W-1:0] c);
        int e = 0;
        for (int r = 0; r < SIZE; r++) begin
            for (int k = 0; k < SIZE; k++) begin
                bit h;
                int wx = x0 + k;
                int wy = y0 + r;
                case (m)
                    0:       h = (k == 0) || (k == SIZE - 1) || (r == 0) || (r == SIZE - 1);
                    1:       h = 1'b1;
                    2:       h = (k == SIZE / 2) || (r == SIZE / 2);
                    default: h = (k == r) || (k + r == SIZE - 1);
                endcase
                if (h && wx < SCREEN_W && wy < SCREEN_H) begin
                    expQ.push_back('{x: OUT_W'(wx), y: OUT_W'(wy), d: c});
                    e++;
                end
            end
        end
        return e;
    endfunction

    // Monitor: writes are taken on the edge where paint and paint_ready are both high.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            holdValid = 1'b0;
        end else begin
            if (paint) begin
                if (holdValid) begin
                    checks++;
                    if ({out_x, out_y, px_data} !== holdVal) begin
                        errors++;
                        $display("[TB] FAIL hold actual=(%0d,%0d,%h) expected=(%0d,%0d,%h)",
                                 out_x, out_y, px_data, holdVal.x, holdVal.y, holdVal.d);
                    end
                end
                checks++;
                if (out_x >= OUT_W'(SCREEN_W) || out_y >= OUT_W'(SCREEN_H)) begin
                    errors++;
                    $display("[TB] FAIL onscreen actual=(%0d,%0d) expected below (%0d,%0d)",
                             out_x, out_y, SCREEN_W, SCREEN_H);
                end
                if (paint_ready) begin
                    wr_t e;
                    acceptCount++;
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL write actual=(%0d,%0d,%h) expected=none", out_x, out_y, px_data);
                    end else begin
                        e = expQ.pop_front();
                        if ({out_x, out_y, px_data} !== e) begin
                            errors++;
                            $display("[TB] FAIL write actual=(%0d,%0d,%h) expected=(%0d,%0d,%h)",
                                     out_x, out_y, px_data, e.x, e.y, e.d);
                        end
                    end
                    holdValid = 1'b0;
                end else begin
                    holdValid = 1'b1;
                    holdVal   = {out_x, out_y, px_data};
                end
            end else begin
                holdValid = 1'b0;
            end
            if (cursor_done) doneCount++;
        end
    end

    task automatic applyStimulus(input int x, input int y, input int m, input logic [PX_W-1:0] c,
                                 input bit rnd, input int expWrites, input int expCycles);
        int e;
        int cyc;
        readyRandom = rnd;
        acceptCount = 0;
        doneCount   = 0;
        e = modelPush(x, y, m, c);
        init  = 1'b1;
        in_x  = COORD_W'(x);
        in_y  = COORD_W'(y);
        mode  = 2'(m);
        color = c;
        @(posedge clk); #1;
        init  = 1'b0;
        in_x  = COORD_W'($urandom);
        in_y  = COORD_W'($urandom);
        mode  = 2'($urandom);
        color = PX_W'($urandom);
        checkOutput("busyStart", busy, 1);
        cyc = 0;
        while (!cursor_done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (rnd && cyc == 10) init = 1'b1;
            if (rnd && cyc == 11) init = 1'b0;
        end
        checkOutput("doneSeen", cursor_done, 1);
        checkOutput("busyAtDone", busy, 1);
        if (!rnd) checkOutput("doneCycle", cyc, 2 * e + (SIZE * SIZE - e) + 1);
        if (expCycles >= 0) checkOutput("doneCycleLit", cyc, expCycles);
        @(posedge clk); #1;
        checkOutput("doneFall", cursor_done, 0);
        checkOutput("busyFall", busy, 0);
        readyRandom = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("donePulses", doneCount, 1);
        checkOutput("writeCount", acceptCount, e);
        if (expWrites >= 0) checkOutput("writeCountLit", acceptCount, expWrites);
        checkOutput("queueEmpty", expQ.size(), 0);
        checkOutput("idleBusy", busy, 0);
        expQ.delete();
    endtask

    task automatic resetMidDraw();
        int e;
        readyRandom = 1'b0;
        doneCount   = 0;
        e = modelPush(10, 20, 1, 8'h5A);
        init = 1'b1; in_x = 6'd10; in_y = 6'd20; mode = 2'd1; color = 8'h5A;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("rstPaint", paint, 0);
        checkOutput("rstOutX", out_x, 0);
        checkOutput("rstOutY", out_y, 0);
        checkOutput("rstPx", px_data, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", cursor_done, 0);
        expQ.delete();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("postRstBusy", busy, 0);
        checkOutput("postRstPaint", paint, 0);
        checkOutput("postRstDone", doneCount, 0);
    endtask

    initial begin
        rst = 1'b0; init = 1'b0; in_x = '0; in_y = '0; mode = '0; color = '0;
        #1;
        checkOutput("resetPaint", paint, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", cursor_done, 0);
        #11;
        rst = 1'b1;
        @(posedge clk); #1;

        resetMidDraw();
        applyStimulus(10, 20, 1, 8'hA5, 1'b0, 25, 51);
        applyStimulus(0, 0, 0, 8'h3C, 1'b0, 16, 42);
        applyStimulus(0, 0, 2, 8'h11, 1'b0, 9, 35);
        applyStimulus(5, 5, 3, 8'h77, 1'b0, 9, 35);
        applyStimulus(62, 61, 1, 8'hC3, 1'b0, 6, 32);
        applyStimulus(63, 63, 1, 8'h0F, 1'b0, 1, 27);
        applyStimulus(10, 20, 1, 8'hA5, 1'b1, 25, -1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                          int'($urandom_range(0, 3)), PX_W'($urandom), 1'(i % 2), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
